i2c_target: RTL and testbench
=============================

# i2c_target

Single-address I2C target (slave) that sits directly downstream of `I2C_Controller` on the shared open-drain SDA/SCL pair, terminating the transactions the controller issues. It oversamples the bus with the system clock and detects START/STOP. It matches its 7-bit address, ACKs, and assembles write bytes into a 32-bit register. For read transactions it serves bytes from a 32-bit input word. It also acts as the reference target for controller bring-up.

## Interface
- `ADDRESS`, 7'h1F, 7-bit bus address this target answers to.
- `SYNC_STAGES`, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i2c_scl`  in  1  bus clock; the block never drives or stretches SCL.
- `i2c_sda`  inout  1  bus data; the block drives only `1'b0` or `1'bz`.
- `tx_data`  in  32  read-response word, latched at the address ACK of a read.
- `rx_data`  out  32  received write bytes, shifted in MSB-first from the LSB end.
- `rx_valid`  out  1  one-cycle pulse per completed write byte.
- `rx_count`  out  3  bytes received in the current/last write transaction; saturates at 7.
- `addr_match`  out  1  one-cycle pulse when the address byte matches `ADDRESS`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- SCL and SDA each pass through `SYNC_STAGES` flops, then one edge-detect register.
- All decisions use the synchronised values.
- START is SDA falling while SCL is high.
- STOP is SDA rising while SCL is high.
- SDA is sampled on the synchronised SCL rising edge.
- The SDA drive (`sda_oe`) changes only on the synchronised SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- IDLE: on START go to ADDR, clear the bit counter, and clear `rx_count`.
- ADDR: shift in 8 bits (7 address bits, then R/W).
  - On match: pulse `addr_match` and go to ADDR_ACK.
  - On mismatch: go to WAIT_STOP with SDA released (NACK).
- ADDR_ACK: drive SDA low for one SCL high period.
  - For R/W=0, go to WRITE on the following SCL fall.
  - For R/W=1, load the shift register from `tx_data`, drive bit 31, and go to READ.
- WRITE: after 8 bits, set `rx_data <= {rx_data[23:0], byte}`, pulse `rx_valid`, increment `rx_count` (saturating), and go to WRITE_ACK.
  - WRITE_ACK drives SDA low for one bit, then returns to WRITE.
- READ: output bytes MSB-first, rotating the 32-bit word so byte 5 repeats byte 1.
  - After 8 bits, release SDA and go to READ_ACK to sample the controller's ACK.
  - ACK (SDA=0): go back to READ with the next byte.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released; ignore bus activity except START and STOP.
- A START in any state (repeated START) goes to ADDR and clears `rx_count`.
- A STOP in any state goes to IDLE and releases SDA.
- A START/STOP coincident with an SCL edge is handled as START/STOP, not as a data bit.

## Timing
- Reset values: `sda_oe`=0 (SDA high-Z), state IDLE, `rx_data`=0, `rx_count`=0, `rx_valid`=0, `addr_match`=0, `busy`=0.
- Reset is asynchronous: SDA is released in the same cycle `reset_n` falls, including mid-byte.
- Pin-to-action latency is `SYNC_STAGES`+1 clocks from a pin edge.
  - This applies to SDA drive after an SCL fall and to START/STOP detection.
- `rx_valid` and `addr_match` assert 1 clock after the detecting edge and last exactly 1 clock.
- `rx_data` and `rx_count` are stable in the cycle `rx_valid` is high.
- `tx_data` is sampled in exactly one cycle per read transaction: the ADDR_ACK-to-READ transition.
- Bus requirement: SCL low and high phases each at least `SYNC_STAGES`+3 system clocks.

## Test plan
- Single-byte write: START, 0x3E (0x1F,W), 0x20, STOP -> ACK on both bytes; one `addr_match` pulse; one `rx_valid`; `rx_data`=0x00000020; `rx_count`=1; `busy` low after STOP.
- Four-byte write: address 0x1F,W then 0xDE,0xAD,0xBE,0xEF -> 4 ACKs; 4 `rx_valid` pulses; `rx_data`=0xDEADBEEF; `rx_count`=4.
- Address mismatch: START, 0x54 (0x2A,W), 0xFF, STOP -> SDA high on every ACK slot; no `addr_match` or `rx_valid`; `busy` falls after STOP.
- Read: `tx_data`=0x12345678; address 0x1F,R; controller ACKs 3 bytes and NACKs the 4th -> bus carries 0x12,0x34,0x56,0x78; SDA released after the 4th byte; WAIT_STOP until STOP.
- Repeated START: write 0xAA, then repeated START with 0x1F,R -> `rx_count` cleared to 0; `rx_data` bits [7:0]=0xAA retained; read returns `tx_data[31:24]`.
- Reset mid-read: assert `reset_n` low during bit 3 of a read byte driving 0 -> SDA high-Z in the same cycle; all outputs at reset values; next START/0x3E is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// Single-address I2C target: oversamples SCL/SDA, detects START/STOP, ACKs its
// address, collects write bytes into a 32-bit word and serves reads from tx_data.
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h1F,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic [2:0]  rx_count,
    output logic        addr_match,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_WRITE     = 3'd3,
        S_WRITE_ACK = 3'd4,
        S_READ      = 3'd5,
        S_READ_ACK  = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [31:0] r_tx;
    logic        r_rw;
    logic        r_nack;
    logic        r_sda_oe;
    logic [31:0] r_rx_data;
    logic [2:0]  r_rx_count;
    logic        r_rx_valid;
    logic        r_addr_match;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    // Input synchronisers plus one edge-detect stage; idle bus reads as high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // Protocol FSM; bus conditions take priority over data bits on the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_tx         <= 32'd0;
            r_rw         <= 1'b0;
            r_nack       <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 32'd0;
            r_rx_count   <= 3'd0;
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
            end else if (w_start) begin
                r_state    <= S_ADDR;
                r_bit_cnt  <= 4'd0;
                r_rx_count <= 3'd0;
                r_sda_oe   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                if (w_byte[7:1] == ADDRESS) begin
                                    r_addr_match <= 1'b1;
                                    r_rw         <= w_byte[0];
                                    r_state      <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    // First SCL fall asserts the ACK, the second one ends it.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                r_tx      <= tx_data;
                                r_sda_oe  <= ~tx_data[31];
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_READ;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_rx_data  <= {r_rx_data[23:0], w_byte};
                                r_rx_valid <= 1'b1;
                                r_rx_count <= (r_rx_count == 3'd7) ? 3'd7 : r_rx_count + 3'd1;
                                r_state    <= S_WRITE_ACK;
                            end
                        end
                    end
                    S_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_WRITE;
                            end
                        end
                    end
                    // The word rotates one bit per SCL fall, so byte 5 repeats byte 1.
                    S_READ: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            r_tx <= {r_tx[30:0], r_tx[31]};
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_READ_ACK;
                            end else begin
                                r_sda_oe <= ~r_tx[30];
                            end
                        end
                    end
                    S_READ_ACK: begin
                        if (w_scl_rise) begin
                            r_nack    <= w_sda;
                            r_bit_cnt <= 4'd9;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd9)) begin
                            if (r_nack) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WAIT_STOP;
                            end else begin
                                r_sda_oe  <= ~r_tx[31];
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_READ;
                            end
                        end
                    end
                    S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c_sda    = r_sda_oe ? 1'b0 : 1'bz;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_count   = r_rx_count;
    assign addr_match = r_addr_match;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C controller plus a byte-level model of
// what the target should acknowledge, return and report.
module tb_i2c_target;

    localparam int         Q    = 6;
    localparam logic [6:0] ADDR = 7'h1F;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        scl       = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [31:0] tx_data   = 32'd0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [2:0]  rx_count;
    logic        addr_match;
    logic        busy;
    wire         sda_w;

    pullup (sda_w);
    assign sda_w = m_sda_low ? 1'b0 : 1'bz;

    i2c_target #(.ADDRESS(ADDR), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .i2c_scl   (scl),
        .i2c_sda   (sda_w),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .addr_match(addr_match),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rxv   = 0;
    int          n_am    = 0;
    int          n_long  = 0;
    int          exp_rxv = 0;
    int          exp_am  = 0;
    logic        prev_rxv = 1'b0;
    logic        prev_am  = 1'b0;
    logic [34:0] q_obs[$];
    logic [34:0] q_exp[$];
    logic [7:0]  q_wr[$];
    logic [31:0] m_data  = 32'd0;
    int          m_count = 0;

    // Pulse monitor: counts strobes, flags strobes wider than one clock.
    always @(negedge clock) begin
        if (rx_valid) begin
            n_rxv++;
            q_obs.push_back({rx_count, rx_data});
        end
        if (addr_match) n_am++;
        if (rx_valid && prev_rxv) n_long++;
        if (addr_match && prev_am) n_long++;
        prev_rxv = rx_valid;
        prev_am  = addr_match;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_start;
        m_sda_low = 1'b0; wclk(Q);
        scl = 1'b1;       wclk(Q);
        m_sda_low = 1'b1; wclk(Q);
        scl = 1'b0;       wclk(Q);
    endtask

    task automatic bus_stop;
        m_sda_low = 1'b1; wclk(Q);
        scl = 1'b1;       wclk(Q);
        m_sda_low = 1'b0; wclk(Q);
    endtask

    task automatic put_bit(input bit b);
        m_sda_low = !b; wclk(Q);
        scl = 1'b1;     wclk(2*Q);
        scl = 1'b0;     wclk(Q);
    endtask

    task automatic get_bit(output bit b);
        m_sda_low = 1'b0; wclk(Q);
        scl = 1'b1;       wclk(Q);
        b = sda_w;        wclk(Q);
        scl = 1'b0;       wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input bit ack);
        bit b;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(!ack);
    endtask

    // One START-delimited segment: address byte, then n data bytes.
    task automatic seg(input logic [6:0] a, input bit rw, input int n, input logic [31:0] tx);
        bit          ack;
        bit          match;
        logic [7:0]  d;
        logic [7:0]  got;
        logic [31:0] word;
        match   = (a == ADDR);
        tx_data = tx;
        bus_start;
        m_count = 0;
        send_byte({a, rw}, ack);
        check_eq("addr_ack", 64'(ack), 64'(!match));
        check_eq("busy_in_txn", 64'(busy), 64'd1);
        if (match) exp_am++;
        tx_data = $urandom;
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                d = (q_wr.size() != 0) ? q_wr.pop_front() : 8'($urandom);
                send_byte(d, ack);
                check_eq("data_ack", 64'(ack), 64'(!match));
                if (match) begin
                    m_data = {m_data[23:0], d};
                    if (m_count < 7) m_count++;
                    q_exp.push_back({3'(m_count), m_data});
                    exp_rxv++;
                end
            end
        end else if (match) begin
            word = tx;
            for (int i = 0; i < n; i++) begin
                recv_byte(got, i < n - 1);
                check_eq("rd_byte", 64'(got), 64'(word[31:24]));
                word = {word[23:0], word[31:24]};
            end
            wclk(2);
            check_eq("rd_release", 64'(sda_w), 64'd1);
            check_eq("rd_wait_stop_busy", 64'(busy), 64'd1);
        end
    endtask

    task automatic finish_txn;
        logic [34:0] o;
        logic [34:0] e;
        bus_stop;
        wclk(4);
        check_eq("busy_after_stop", 64'(busy), 64'd0);
        check_eq("rx_data", 64'(rx_data), 64'(m_data));
        check_eq("rx_count", 64'(rx_count), 64'(m_count));
        check_eq("rx_valid_count", 64'(n_rxv), 64'(exp_rxv));
        check_eq("addr_match_count", 64'(n_am), 64'(exp_am));
        check_eq("pulse_width", 64'(n_long), 64'd0);
        check_eq("rx_log_len", 64'(q_obs.size()), 64'(q_exp.size()));
        while (q_obs.size() != 0 && q_exp.size() != 0) begin
            o = q_obs.pop_front();
            e = q_exp.pop_front();
            check_eq("rx_strobe_snapshot", 64'(o), 64'(e));
        end
        q_obs.delete();
        q_exp.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sda"}, 64'(sda_w), 64'd1);
        check_eq({tag, "_rx_data"}, 64'(rx_data), 64'd0);
        check_eq({tag, "_rx_count"}, 64'(rx_count), 64'd0);
        check_eq({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
        check_eq({tag, "_addr_match"}, 64'(addr_match), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit          ack;
        bit          b;
        logic [6:0]  a;
        bit          rw;
        int          n;

        wclk(5);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wclk(5);

        q_wr.push_back(8'h20);
        seg(ADDR, 1'b0, 1, 32'd0);
        finish_txn;
        check_eq("single_write_data", 64'(rx_data), 64'h20);

        q_wr.push_back(8'hDE); q_wr.push_back(8'hAD);
        q_wr.push_back(8'hBE); q_wr.push_back(8'hEF);
        seg(ADDR, 1'b0, 4, 32'd0);
        finish_txn;
        check_eq("four_write_data", 64'(rx_data), 64'hDEADBEEF);
        check_eq("four_write_count", 64'(rx_count), 64'd4);

        q_wr.push_back(8'hFF);
        seg(7'h2A, 1'b0, 1, 32'd0);
        finish_txn;

        seg(ADDR, 1'b1, 4, 32'h12345678);
        finish_txn;

        q_wr.push_back(8'hAA);
        seg(ADDR, 1'b0, 1, 32'd0);
        seg(ADDR, 1'b1, 1, 32'hC3A5_0F96);
        finish_txn;
        check_eq("rstart_count", 64'(rx_count), 64'd0);
        check_eq("rstart_data_lsb", 64'(rx_data[7:0]), 64'hAA);

        seg(ADDR, 1'b0, 9, 32'd0);
        finish_txn;
        check_eq("saturated_count", 64'(rx_count), 64'd7);

        // Reset while the target is driving a 0 data bit of a read.
        tx_data = 32'd0;
        bus_start;
        send_byte({ADDR, 1'b1}, ack);
        check_eq("rst_addr_ack", 64'(ack), 64'd0);
        exp_am++;
        for (int i = 0; i < 3; i++) get_bit(b);
        m_sda_low = 1'b0; wclk(Q);
        scl = 1'b1;       wclk(Q);
        check_eq("rd_drive_low", 64'(sda_w), 64'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_data  = 32'd0;
        m_count = 0;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
        reset_n = 1'b1;
        wclk(Q);
        seg(ADDR, 1'b0, 1, 32'd0);
        finish_txn;

        for (int t = 0; t < 12; t++) begin
            for (int s = 0; s < (($urandom_range(0, 3) == 0) ? 2 : 1); s++) begin
                rw = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) != 0) begin
                    a = ADDR;
                end else begin
                    a = 7'($urandom);
                    if (a == ADDR) a = a ^ 7'h01;
                end
                n = $urandom_range(1, 9);
                seg(a, rw, n, $urandom);
            end
            finish_txn;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
